demux_1x8_reg: RTL and testbench
================================

Name: demux_1x8_reg

Overview:
- Registered 1-to-8 demultiplexer: routes data input `in` to one of eight outputs y0..y7, chosen by 3-bit `sel`.
- Built hierarchically: a 1x2 stage on sel[2] feeds two 1x4 stages on sel[1:0], followed by an output register bank.
- Used as a generic data-routing leaf in datapaths that need glitch-free, clock-aligned outputs.

Parameters:
- DATA_W, 1, width in bits of `in` and of each output y0..y7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  DATA_W  data to route.
- sel  input  3  destination select; value k selects output yk.
- y0  output  DATA_W  routed data when sel=3'b000, else 0.
- y1  output  DATA_W  routed data when sel=3'b001, else 0.
- y2  output  DATA_W  routed data when sel=3'b010, else 0.
- y3  output  DATA_W  routed data when sel=3'b011, else 0.
- y4  output  DATA_W  routed data when sel=3'b100, else 0.
- y5  output  DATA_W  routed data when sel=3'b101, else 0.
- y6  output  DATA_W  routed data when sel=3'b110, else 0.
- y7  output  DATA_W  routed data when sel=3'b111, else 0.

Behaviour:
- Combinational routing structure:
  - 1x2 stage: sel[2]=0 passes `in` to the lower branch (y0..y3) and drives 0 on the upper branch; sel[2]=1 does the reverse (upper branch y4..y7).
  - Each 1x4 stage uses sel[1:0] to pass its branch input to exactly one of its four outputs; the other three are 0.
  - The 1x2 and 1x4 stages are separate submodules, instantiated once and twice respectively.
- Output register:
  - All eight outputs are registered on the rising edge of clk.
  - Latency is exactly 1 cycle: values of in/sel sampled at edge N appear on y0..y7 after edge N and hold until edge N+1.
- One-hot routing rule:
  - After any non-reset edge, at most one output is nonzero: the one indexed by the sampled sel.
  - All unselected outputs are all-zero across the full DATA_W.
  - If in=0, all eight outputs are 0.
- Reset:
  - rst=1 at a rising edge sets y0..y7 to 0, regardless of in and sel.
  - rst has priority over data; there is no asynchronous effect.
  - If rst is asserted mid-stream, the outputs are 0 on the next edge.
  - Normal routing resumes on the first edge with rst=0, using the in/sel values sampled at that edge.
- Simultaneous changes: when sel and in change together before an edge, the outputs reflect the new pair only. No intermediate or mixed state is ever registered.
- X/undefined sel: not supported. The bench drives only defined values.
- Sizing: no internal state other than the 8×DATA_W output register.

Test Plan:
- Reset: hold rst=1 with in=1, sel=3'b101 for 2 cycles -> y0..y7 all 0. Release rst -> after the next edge y5=1 and all others 0.
- Zero data sweep: rst=0, in=0, sel stepped 000..111, one value per cycle -> every output stays 0 in every cycle.
- One-hot sweep: in=1, sel stepped 000..111, one per cycle -> one cycle after each sel=k, yk=1 and the other seven are 0. Example: sel=3'b011 gives y3=1.
- Latency check: change sel from 3'b000 to 3'b111 with in=1 between edges -> y0 stays 1 until the next edge, then y7=1 and y0=0 (no earlier change).
- Wide data: DATA_W=8, in=8'hA5, sel=3'b110 -> y6=8'hA5 after one edge, all others 8'h00. Then in=8'h3C, sel=3'b001 -> y1=8'h3C and y6 returns to 8'h00.
- Mid-stream reset: in=1, sel=3'b010, pulse rst for 1 cycle -> y2 drops to 0 on the reset edge and returns to 1 on the following edge.

Source files
------------

// File: rtl/demux_1x8_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1x8_reg (with sub-modules demux_1x2, demux_1x4)
//  Brief    : Registered 1-to-8 demultiplexer. A 1x2 stage on sel[2] feeds
//             two 1x4 stages on sel[1:0]; the eight branch outputs are
//             captured in an output register bank (1-cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 1x2 stage: the selected branch receives the data, the other branch is zero.
// ----------------------------------------------------------------------------
module demux_1x2 #(
  parameter int DATA_W = 1
) (
  input  logic [DATA_W-1:0] din,
  input  logic              sel,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  localparam logic [DATA_W-1:0] c_zero = '0;

  assign lo = sel ? c_zero : din;
  assign hi = sel ? din    : c_zero;

endmodule

// ----------------------------------------------------------------------------
// 1x4 stage: exactly one of four outputs carries the data, the rest are zero.
// ----------------------------------------------------------------------------
module demux_1x4 #(
  parameter int DATA_W = 1
) (
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3
);

  // Route din to the output addressed by sel; all others forced to zero.
  always_comb begin
    q0 = '0;
    q1 = '0;
    q2 = '0;
    q3 = '0;
    case (sel)
      2'd0:    q0 = din;
      2'd1:    q1 = din;
      2'd2:    q2 = din;
      default: q3 = din;
    endcase
  end

endmodule

// ----------------------------------------------------------------------------
// Top: hierarchical routing tree followed by the output register bank.
// ----------------------------------------------------------------------------
module demux_1x8_reg #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3,
  output logic [DATA_W-1:0] y4,
  output logic [DATA_W-1:0] y5,
  output logic [DATA_W-1:0] y6,
  output logic [DATA_W-1:0] y7
);

  logic [DATA_W-1:0] w_lo_branch;
  logic [DATA_W-1:0] w_hi_branch;
  logic [DATA_W-1:0] w_d [8];
  logic [DATA_W-1:0] r_y [8];

  demux_1x2 #(.DATA_W(DATA_W)) u_stage_top (
    .din (in),
    .sel (sel[2]),
    .lo  (w_lo_branch),
    .hi  (w_hi_branch)
  );

  demux_1x4 #(.DATA_W(DATA_W)) u_stage_lo (
    .din (w_lo_branch),
    .sel (sel[1:0]),
    .q0  (w_d[0]),
    .q1  (w_d[1]),
    .q2  (w_d[2]),
    .q3  (w_d[3])
  );

  demux_1x4 #(.DATA_W(DATA_W)) u_stage_hi (
    .din (w_hi_branch),
    .sel (sel[1:0]),
    .q0  (w_d[4]),
    .q1  (w_d[5]),
    .q2  (w_d[6]),
    .q3  (w_d[7])
  );

  // Capture the routed values; reset clears every output and wins over data.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (rst) r_y[k] <= '0;
      else     r_y[k] <= w_d[k];
    end
  end

  assign y0 = r_y[0];
  assign y1 = r_y[1];
  assign y2 = r_y[2];
  assign y3 = r_y[3];
  assign y4 = r_y[4];
  assign y5 = r_y[5];
  assign y6 = r_y[6];
  assign y7 = r_y[7];

endmodule
`default_nettype wire

// File: tb/tb_demux_1x8_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1x8_reg
//  Brief    : Self-checking bench for demux_1x8_reg (DATA_W = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1x8_reg;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in  = '0;
  logic [2:0]        sel = '0;
  logic [DATA_W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;

  int total = 0;
  int bad   = 0;

  // Model state: expected value of each output after the latest edge.
  logic [DATA_W-1:0] exp_y [8];
  bit                armed = 1'b0;

  demux_1x8_reg #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .sel (sel),
    .y0  (y0),
    .y1  (y1),
    .y2  (y2),
    .y3  (y3),
    .y4  (y4),
    .y5  (y5),
    .y6  (y6),
    .y7  (y7)
  );

  always #5 clk = ~clk;

  // Behavioural model: after each edge the sampled data sits at index sel,
  // everything else is zero; reset zeroes all.
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) exp_y[k] = '0;
    if (rst) armed = 1'b1;
    else     exp_y[sel] = in;
  end

  function automatic logic [8*DATA_W-1:0] actual_vec();
    return {y7, y6, y5, y4, y3, y2, y1, y0};
  endfunction

  function automatic logic [8*DATA_W-1:0] model_vec();
    logic [8*DATA_W-1:0] v;
    for (int k = 0; k < 8; k++) v[k*DATA_W +: DATA_W] = exp_y[k];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison of all eight outputs against the model.
  always @(negedge clk) begin
    if (armed) check("model", 64'(actual_vec()), 64'(model_vec()));
  end

  // Drive one vector before the edge, return just after it.
  task automatic step(input logic r, input logic [DATA_W-1:0] d, input logic [2:0] s);
    @(negedge clk);
    rst = r;
    in  = d;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with live data on the inputs.
    step(1'b1, 8'h01, 3'd5);
    step(1'b1, 8'h01, 3'd5);
    check("reset_all_zero", 64'(actual_vec()), 64'h0);

    // Release: routing resumes on the first edge without reset.
    step(1'b0, 8'h01, 3'd5);
    check("release_y5", 64'(actual_vec()), 64'h0000_0100_0000_0000);

    // Zero data sweep.
    for (int s = 0; s < 8; s++) step(1'b0, 8'h00, 3'(s));
    check("zero_sweep_end", 64'(actual_vec()), 64'h0);

    // One-hot sweep.
    for (int s = 0; s < 8; s++) begin
      step(1'b0, 8'h01, 3'(s));
      if (s == 3) check("onehot_y3", 64'(actual_vec()), 64'h0000_0000_0100_0000);
    end

    // Latency: select change between edges must not show before the edge.
    step(1'b0, 8'h01, 3'd0);
    #1 sel = 3'd7;
    #1;
    check("latency_y0_held", 64'(y0), 64'h1);
    check("latency_y7_idle", 64'(y7), 64'h0);
    step(1'b0, 8'h01, 3'd7);
    check("latency_after", 64'(actual_vec()), 64'h0100_0000_0000_0000);

    // Wide data.
    step(1'b0, 8'hA5, 3'd6);
    check("wide_y6", 64'(actual_vec()), 64'h00A5_0000_0000_0000);
    step(1'b0, 8'h3C, 3'd1);
    check("wide_y1", 64'(y1), 64'h3C);
    check("wide_y6_clear", 64'(y6), 64'h0);

    // Simultaneous in/sel change: only the new pair is registered.
    step(1'b0, 8'hFF, 3'd4);
    check("simul_y4", 64'(actual_vec()), 64'h0000_00FF_0000_0000);

    // Mid-stream reset pulse.
    step(1'b0, 8'h01, 3'd2);
    check("mid_y2_before", 64'(y2), 64'h1);
    step(1'b1, 8'h01, 3'd2);
    check("mid_reset", 64'(actual_vec()), 64'h0);
    step(1'b0, 8'h01, 3'd2);
    check("mid_resume", 64'(actual_vec()), 64'h0000_0000_0001_0000);

    // A few further directed vectors for the model check.
    step(1'b0, 8'h80, 3'd0);
    step(1'b0, 8'h5A, 3'd3);
    step(1'b0, 8'h00, 3'd7);
    step(1'b0, 8'h7E, 3'd5);
    check("final_y5", 64'(y5), 64'h7E);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
